// File: rtl/yutorina_reset_ctrl.sv
// Chip reset controller. Synchronises and debounces a reset push-switch, watches
// clock-generator lock, and sequences chip_rst through WAIT_LOCK / HOLD / RUN.
module yutorina_reset_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rst_sw,
  input  logic       locked,
  output logic       chip_rst,
  output logic [1:0] rst_state,
  output logic [1:0] rst_cause,
  output logic [7:0] rst_count
);

  localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  localparam logic [1:0] CAUSE_POR    = 2'b00;
  localparam logic [1:0] CAUSE_SWITCH = 2'b01;
  localparam logic [1:0] CAUSE_LOCK   = 2'b10;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'b00,
    HOLD      = 2'b01,
    RUN       = 2'b10
  } state_t;

  logic            sw_s1, sw_s2, lk_s1, lk_s2;
  logic [DB_W-1:0] db_cnt;
  logic            db_level, db_prev;

  state_t            state, next_state;
  logic [HOLD_W-1:0] hold_cnt, next_hold_cnt;
  logic [1:0]        next_cause;
  logic [7:0]        next_count, count_inc;
  logic              sw_rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_s1 <= 1'b0;
      sw_s2 <= 1'b0;
      lk_s1 <= 1'b0;
      lk_s2 <= 1'b0;
    end else begin
      sw_s1 <= rst_sw;
      sw_s2 <= sw_s1;
      lk_s1 <= locked;
      lk_s2 <= lk_s1;
    end
  end

  // The level only flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt   <= '0;
      db_level <= 1'b0;
      db_prev  <= 1'b0;
    end else begin
      db_prev <= db_level;
      if (sw_s2 != db_level) begin
        if (db_cnt == DB_LAST) begin
          db_level <= sw_s2;
          db_cnt   <= '0;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  assign sw_rise   = db_level & ~db_prev;
  assign count_inc = (rst_count == 8'hFF) ? 8'hFF : rst_count + 8'd1;

  always_comb begin
    next_state    = state;
    next_hold_cnt = hold_cnt;
    next_cause    = rst_cause;
    next_count    = rst_count;
    case (state)
      WAIT_LOCK: begin
        if (lk_s2) begin
          next_state    = HOLD;
          next_hold_cnt = '0;
        end
      end
      HOLD: begin
        if (!lk_s2) begin
          next_state = WAIT_LOCK;
        end else if (db_level) begin
          next_hold_cnt = '0;
        end else if (hold_cnt == HOLD_LAST) begin
          next_state = RUN;
        end else begin
          next_hold_cnt = hold_cnt + HOLD_W'(1);
        end
      end
      RUN: begin
        // Lock loss wins over a simultaneous switch press.
        if (!lk_s2) begin
          next_state = WAIT_LOCK;
          next_cause = CAUSE_LOCK;
          next_count = count_inc;
        end else if (sw_rise) begin
          next_state    = HOLD;
          next_hold_cnt = '0;
          next_cause    = CAUSE_SWITCH;
          next_count    = count_inc;
        end
      end
      default: begin
        next_state = WAIT_LOCK;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= WAIT_LOCK;
      hold_cnt  <= '0;
      chip_rst  <= 1'b1;
      rst_cause <= CAUSE_POR;
      rst_count <= 8'd0;
    end else begin
      state     <= next_state;
      hold_cnt  <= next_hold_cnt;
      chip_rst  <= (next_state != RUN);
      rst_cause <= next_cause;
      rst_count <= next_count;
    end
  end

  assign rst_state = state;

endmodule

// File: tb/tb_yutorina_reset_ctrl.sv
// Self-checking bench for yutorina_reset_ctrl: a cycle-level behavioural model
// compared on every falling edge, plus directed scenarios with literal expectations.
module tb_yutorina_reset_ctrl;

  localparam int DB = 16;
  localparam int HC = 8;

  logic       clk = 1'b0;
  logic       rst, rst_sw, locked;
  logic       chip_rst;
  logic [1:0] rst_state, rst_cause;
  logic [7:0] rst_count;

  int checks = 0;
  int errors = 0;

  yutorina_reset_ctrl #(.DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HC)) dut (
    .clk(clk),
    .rst(rst),
    .rst_sw(rst_sw),
    .locked(locked),
    .chip_rst(chip_rst),
    .rst_state(rst_state),
    .rst_cause(rst_cause),
    .rst_count(rst_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit sw, input bit lk, input int n);
    rst    = r;
    rst_sw = sw;
    locked = lk;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Behavioural model: synchronisers are two-deep delay queues, the debouncer is
  // a sliding window of the last DB synced samples, and HOLD counts quiet cycles.
  bit m_valid = 1'b0;
  int m_mode, m_quiet, m_cause, m_count;
  bit m_db, m_db_prev;
  bit sw_pipe[$];
  bit lk_pipe[$];
  bit win[$];
  bit lk_now, sw_now, rise, all_diff;

  always @(posedge clk) begin
    if (rst) begin
      m_valid   = 1'b1;
      m_mode    = 0;
      m_quiet   = 0;
      m_cause   = 0;
      m_count   = 0;
      m_db      = 1'b0;
      m_db_prev = 1'b0;
      sw_pipe   = {1'b0, 1'b0};
      lk_pipe   = {1'b0, 1'b0};
      win.delete();
    end else if (m_valid) begin
      lk_now = lk_pipe.pop_front();
      lk_pipe.push_back(locked);
      sw_now = sw_pipe.pop_front();
      sw_pipe.push_back(rst_sw);
      rise = m_db && !m_db_prev;
      case (m_mode)
        0: if (lk_now) begin m_mode = 1; m_quiet = 0; end
        1: begin
          if (!lk_now) m_mode = 0;
          else if (m_db) m_quiet = 0;
          else begin
            m_quiet++;
            if (m_quiet == HC) m_mode = 2;
          end
        end
        default: begin
          if (!lk_now) begin
            m_mode = 0; m_cause = 2;
            if (m_count < 255) m_count++;
          end else if (rise) begin
            m_mode = 1; m_quiet = 0; m_cause = 1;
            if (m_count < 255) m_count++;
          end
        end
      endcase
      m_db_prev = m_db;
      win.push_back(sw_now);
      if (win.size() > DB) void'(win.pop_front());
      all_diff = (win.size() == DB);
      foreach (win[i]) if (win[i] == m_db) all_diff = 1'b0;
      if (all_diff) m_db = !m_db;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      checkOutput("model_chip_rst", int'(chip_rst), (m_mode != 2) ? 1 : 0);
      checkOutput("model_state", int'(rst_state), m_mode);
      checkOutput("model_cause", int'(rst_cause), m_cause);
      checkOutput("model_count", int'(rst_count), m_count);
    end
  end

  initial begin
    rst = 1'b1; rst_sw = 1'b0; locked = 1'b1;
    applyStimulus(1, 0, 1, 3);
    checkOutput("por_chip_rst", int'(chip_rst), 1);
    checkOutput("por_state", int'(rst_state), 0);
    checkOutput("por_cause", int'(rst_cause), 0);
    checkOutput("por_count", int'(rst_count), 0);

    // Power-up: HOLD on 3rd edge, RUN on 11th.
    applyStimulus(0, 0, 1, 2);
    checkOutput("pu_state_e2", int'(rst_state), 0);
    applyStimulus(0, 0, 1, 1);
    checkOutput("pu_state_e3", int'(rst_state), 1);
    applyStimulus(0, 0, 1, 7);
    checkOutput("pu_chip_e10", int'(chip_rst), 1);
    applyStimulus(0, 0, 1, 1);
    checkOutput("pu_chip_e11", int'(chip_rst), 0);
    checkOutput("pu_state_e11", int'(rst_state), 2);

    // Short glitch is filtered out.
    applyStimulus(0, 1, 1, 10);
    applyStimulus(0, 0, 1, 30);
    checkOutput("glitch_state", int'(rst_state), 2);
    checkOutput("glitch_count", int'(rst_count), 0);

    // Long press: reset on 19th edge, release debounce + 8 HOLD cycles.
    applyStimulus(0, 1, 1, 18);
    checkOutput("press_chip_e18", int'(chip_rst), 0);
    applyStimulus(0, 1, 1, 1);
    checkOutput("press_chip_e19", int'(chip_rst), 1);
    checkOutput("press_cause", int'(rst_cause), 1);
    checkOutput("press_count", int'(rst_count), 1);
    applyStimulus(0, 1, 1, 21);
    applyStimulus(0, 0, 1, 25);
    checkOutput("release_chip_e25", int'(chip_rst), 1);
    applyStimulus(0, 0, 1, 1);
    checkOutput("release_chip_e26", int'(chip_rst), 0);

    // Lock loss for 5 cycles.
    applyStimulus(0, 0, 0, 2);
    checkOutput("lock_chip_e2", int'(chip_rst), 0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("lock_state_e3", int'(rst_state), 0);
    checkOutput("lock_cause", int'(rst_cause), 2);
    checkOutput("lock_count", int'(rst_count), 2);
    applyStimulus(0, 0, 0, 2);
    applyStimulus(0, 0, 1, 10);
    checkOutput("relock_chip_e10", int'(chip_rst), 1);
    applyStimulus(0, 0, 1, 1);
    checkOutput("relock_state_e11", int'(rst_state), 2);

    // Lock loss and debounced press reach RUN on the same edge.
    applyStimulus(0, 1, 1, 16);
    applyStimulus(0, 1, 0, 2);
    checkOutput("both_chip_e18", int'(chip_rst), 0);
    applyStimulus(0, 1, 0, 1);
    checkOutput("both_state", int'(rst_state), 0);
    checkOutput("both_cause", int'(rst_cause), 2);
    checkOutput("both_count", int'(rst_count), 3);
    applyStimulus(0, 0, 1, 60);
    checkOutput("both_recover_state", int'(rst_state), 2);

    // Saturation of the reset counter.
    for (int i = 0; i < 260; i++) begin
      applyStimulus(0, 1, 1, 20);
      applyStimulus(0, 0, 1, 30);
      if (i == 1) checkOutput("sat_count_i1", int'(rst_count), 5);
    end
    checkOutput("sat_count", int'(rst_count), 255);
    checkOutput("sat_state", int'(rst_state), 2);
    checkOutput("sat_cause", int'(rst_cause), 1);
    applyStimulus(0, 1, 1, 20);
    checkOutput("sat_hold_state", int'(rst_state), 1);
    checkOutput("sat_hold_count", int'(rst_count), 255);

    // Synchronous reset in the middle of HOLD.
    applyStimulus(1, 1, 1, 1);
    checkOutput("midrst_state", int'(rst_state), 0);
    checkOutput("midrst_chip", int'(chip_rst), 1);
    checkOutput("midrst_cause", int'(rst_cause), 0);
    checkOutput("midrst_count", int'(rst_count), 0);
    applyStimulus(0, 0, 1, 40);
    checkOutput("final_state", int'(rst_state), 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/yutorina_reset_ctrl.md
YUTORINA_RESET_CTRL -- requirements
Module: yutorina_reset_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16, consecutive stable synced samples required to change debounced switch level.
REQ-002 SHALL have parameter HOLD_CYCLES, default 8, minimum cycles chip_rst stays asserted after all reset causes clear.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port rst_sw  input  1  raw push-switch level, asynchronous to clk, 1 = pressed.
REQ-006 SHALL have port locked  input  1  clock-generator lock, asynchronous to clk, 1 = locked.
REQ-007 SHALL have port chip_rst  output  1  registered reset to chip top / CPU, 1 = reset asserted.
REQ-008 SHALL have port rst_state  output  2  current FSM state: 00 WAIT_LOCK, 01 HOLD, 10 RUN.
REQ-009 SHALL have port rst_cause  output  2  cause of last chip reset: 00 power-on, 01 switch, 10 lock loss.
REQ-010 SHALL have port rst_count  output  8  number of switch/lock-loss resets since rst, saturating.

Function
REQ-011 rst_sw and locked SHALL each pass a 2-flop synchronizer; FSM and debouncer SHALL use only synced values.
REQ-012 Debouncer: counter SHALL increment each edge synced rst_sw differs from debounced level, clear to 0 on any edge they match.
REQ-013 Debounced level SHALL flip (counter cleared) on the edge where the counter equals DEBOUNCE_CYCLES-1 and inputs still differ; pulses shorter than DEBOUNCE_CYCLES synced cycles SHALL have no effect.
REQ-014 WAIT_LOCK: chip_rst=1; on edge with synced locked=1 -> HOLD, hold_cnt=0.
REQ-015 HOLD: chip_rst=1; synced locked=0 -> WAIT_LOCK; else debounced switch=1 -> stay, hold_cnt=0; else hold_cnt+1.
REQ-016 HOLD SHALL go to RUN on the edge following the cycle with hold_cnt=HOLD_CYCLES-1 (HOLD lasts exactly HOLD_CYCLES cycles when undisturbed).
REQ-017 RUN: chip_rst=0; synced locked=0 -> WAIT_LOCK, rst_cause=10, rst_count+1.
REQ-018 RUN: debounced switch rising edge (with locked=1) -> HOLD, hold_cnt=0, rst_cause=01, rst_count+1.
REQ-019 Lock loss SHALL take priority over switch on the same edge; cause=10, count incremented once.
REQ-020 Lock loss in HOLD SHALL not change rst_cause or rst_count (reset already asserted).
REQ-021 chip_rst SHALL be registered and equal 0 exactly on cycles where rst_state=10; no combinational path from inputs.
REQ-022 rst_count SHALL saturate at 255; no wrap.
REQ-023 hold_cnt SHALL be wide enough for HOLD_CYCLES-1; debounce counter for DEBOUNCE_CYCLES-1.

Reset
REQ-024 On edge with rst=1: state=WAIT_LOCK, chip_rst=1, rst_cause=00, rst_count=0, synchronizers, debounced level, all counters = 0.
REQ-025 rst asserted mid-operation (any state) SHALL take effect on that edge, overriding all other transitions.

Verification
REQ-026 rst=1 3 cycles, locked=1, rst_sw=0 constant -> HOLD at 3rd edge after rst drops; chip_rst falls at 11th edge; rst_cause=00, rst_count=0.
REQ-027 In RUN, rst_sw=1 for 10 cycles -> chip_rst stays 0, rst_count=0, state stays RUN.
REQ-028 In RUN, rst_sw=1 for 40 cycles -> chip_rst=1 at 19th edge after press; stays 1 while pressed, through release debounce plus 8 HOLD cycles; rst_cause=01, rst_count=1.
REQ-029 In RUN, locked=0 for 5 cycles -> chip_rst=1 at 3rd edge, state WAIT_LOCK, cause=10, count+1; after relock, 2 sync + 8 HOLD cycles -> RUN.
REQ-030 locked drop timed so lock loss and debounced press hit RUN on same edge -> state WAIT_LOCK, cause=10, count +1 only.
REQ-031 Drive 260 switch resets -> rst_count=255 and holds; rst=1 mid-HOLD -> all outputs at reset values next edge.
